// File: rtl/bram_mult_seq_pkg.sv
// Shared types and constants for the BRAM-fed multiplier sequencer.
package bram_mult_seq_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int WORD_W = 32;

  // Operand packing inside one operand BRAM word
  localparam int A_MSB = 31;
  localparam int A_LSB = 16;
  localparam int B_MSB = 15;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    MULT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/bram_mult_sequencer_start_stop_edge.sv
// Rising-edge detector for start_stop; history is cleared by reset.
module start_stop_edge (
  input  logic clk,
  input  logic rst,
  input  logic start_stop,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= start_stop;
  end

  assign rise = start_stop & ~prev;

endmodule

// File: rtl/bram_mult_sequencer.sv
// Walks the operand BRAM, multiplies each packed pair and writes products to the result BRAM.
// Optional BRAM_SEQ_ACCUM_EN: y shows a wrapping running sum of the pass instead of the last product.
//
// state | meaning
// IDLE  | waiting for a start_stop rising edge
// READ  | operand BRAM read strobe at index
// WAIT  | operand word arrives, multiplier operands registered
// MULT  | multiplier latency, product captured on the last cycle
// WRITE | result BRAM write, y update, stop/last decision
// DONE  | one-cycle completion pulse
module bram_mult_sequencer
  import bram_mult_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_stop,
  output logic              op_en,
  output logic [ADDR_W-1:0] op_addr,
  input  logic [WORD_W-1:0] op_dout,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [PROD_W-1:0] res_din,
  output logic [PROD_W-1:0] y,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MULT_LAT - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   idx;
  logic [CNT_W-1:0]    cnt;
  logic [PROD_W-1:0]   prod;
  logic                rise;

  start_stop_edge u_edge (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .rise       (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      prod  <= '0;
      y     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (rise) begin
          idx <= '0;
`ifdef BRAM_SEQ_ACCUM_EN
          y   <= '0;
`endif
        end
        WAIT: begin
          mul_a <= op_dout[A_MSB:A_LSB];
          mul_b <= op_dout[B_MSB:B_LSB];
          cnt   <= CNT_LOAD;
        end
        // down-counter: product is valid when the count reaches zero
        MULT: begin
          if (cnt == '0) prod <= mul_p;
          else           cnt  <= cnt - 1'b1;
        end
        WRITE: begin
`ifdef BRAM_SEQ_ACCUM_EN
          y <= y + prod;
`else
          y <= prod;
`endif
          if (state_nx == READ) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    op_en    = 1'b0;
    res_we   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (rise) state_nx = READ;
      READ:  begin op_en = 1'b1; state_nx = WAIT; end
      WAIT:  state_nx = MULT;
      MULT:  if (cnt == '0) state_nx = WRITE;
      WRITE: begin
        res_we = 1'b1;
        if (idx == LAST_IDX || !start_stop) state_nx = DONE;
        else                                state_nx = READ;
      end
      DONE:  begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  assign op_addr  = op_en  ? idx  : '0;
  assign res_addr = res_we ? idx  : '0;
  assign res_din  = res_we ? prod : '0;
  assign busy     = (state != IDLE) && (state != DONE);

endmodule
